gb_cart_bus_master: RTL and testbench

// - Initiator side of the Game Boy cartridge bus: turns single-byte host requests into timed cartridge read/write cycles.
// - Drives Cart_a, Cart_nRD, Cart_nWR and Cart_nCS, and the Cart_d tri-state controls. Top-level pads own the actual tri-state.
// - Talks to cartridge-side mappers; bank-select writes (e.g. 0x2000 <- N) are just ordinary write requests.
// - Sits between the host/bridge logic and the cartridge pads, clocked by sys_clock.

---
 rtl/gb_cart_pkg.sv | 22 ++
 rtl/gb_cart_bus_master_if.sv | 43 ++++
 rtl/gb_cart_phase_timer.sv | 33 +++
 rtl/gb_cart_bus_master.sv | 148 ++++++++++++++
 tb/tb_gb_cart_bus_master.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_cart_pkg.sv
// Shared types and constants for the Game Boy cartridge bus master.
// Holds the phase enum, address windows and the cart-RAM decode helper.
package gb_cart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [15:0] CART_RAM_LO     = 16'hA000;
  localparam logic [15:0] CART_RAM_HI     = 16'hBFFF;
  localparam logic [15:0] ROM_BANK_SEL_LO = 16'h2000;

  function automatic logic in_cart_ram(
    input logic [15:0] a
  );
    return (a >= CART_RAM_LO) && (a <= CART_RAM_HI);
  endfunction

endpackage

// File: rtl/gb_cart_bus_master_if.sv
// Host request/response handshake plus cartridge pad-side bus signals.
// master: the bus master block; slave: host and cartridge/pad side.
interface gb_cart_bus_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] Cart_a;
  logic [7:0]  Cart_d_in;
  logic [7:0]  Cart_d_out;
  logic        Cart_d_oe;
  logic        Cart_nRD;
  logic        Cart_nWR;
  logic        Cart_nCS;
  logic        busy;

  modport master (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    input  Cart_d_in,
    output req_ready, rsp_valid,
    output rsp_rdata, Cart_a,
    output Cart_d_out, Cart_d_oe,
    output Cart_nRD, Cart_nWR,
    output Cart_nCS, busy
  );

  modport slave (
    output req_valid, req_write,
    output req_addr, req_wdata,
    output Cart_d_in,
    input  req_ready, rsp_valid,
    input  rsp_rdata, Cart_a,
    input  Cart_d_out, Cart_d_oe,
    input  Cart_nRD, Cart_nWR,
    input  Cart_nCS, busy
  );

endinterface

// File: rtl/gb_cart_phase_timer.sv
// Loadable down-counter timing each bus phase; done_o when it reaches 0.
// Ports: clk_i, rst_i (sync, high), load_i/load_val_i, count_o, done_o.
module gb_cart_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/gb_cart_bus_master.sv
// Turns single-byte host requests into timed Game Boy cartridge cycles.
// Ports: sys_clock, sys_reset (sync, high), bus (req/rsp + Cart_* pads).
module gb_cart_bus_master
  import gb_cart_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int CNT_W      = 4
) (
  input  logic                 sys_clock,
  input  logic                 sys_reset,
  gb_cart_bus_master_if.master bus
);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        nrd_q, nrd_d;
  logic        nwr_q, nwr_d;
  logic        ncs_q, ncs_d;
  logic        rsp_q, rsp_d;
  logic [7:0]  rdata_q, rdata_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic [CNT_W-1:0] cnt;
  logic             done;

  gb_cart_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (sys_clock),
    .rst_i     (sys_reset),
    .load_i    (ld),
    .load_val_i(ld_val),
    .count_o   (cnt),
    .done_o    (done)
  );

  // Every Cart_* output is computed one phase ahead and registered,
  // so nothing from req_* reaches the pads combinationally.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    a_d     = a_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    nrd_d   = nrd_q;
    nwr_d   = nwr_q;
    ncs_d   = ncs_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = SETUP;
          ld      = 1'b1;
          ld_val  = CNT_W'(SETUP_CYC - 1);
          wr_d    = bus.req_write;
          a_d     = bus.req_addr;
          ncs_d   = !in_cart_ram(bus.req_addr);
          rdata_d = 8'h00;
          if (bus.req_write) begin
            dout_d = bus.req_wdata;
            oe_d   = 1'b1;
            nrd_d  = 1'b1;
          end else begin
            oe_d   = 1'b0;
            nrd_d  = 1'b0;
          end
        end
      end
      SETUP: begin
        if (done) begin
          state_d = STROBE;
          ld      = 1'b1;
          ld_val  = CNT_W'(STROBE_CYC - 1);
          if (wr_q) nwr_d = 1'b0;
        end
      end
      STROBE: begin
        if (done) begin
          state_d = HOLD;
          ld      = 1'b1;
          ld_val  = CNT_W'(HOLD_CYC - 1);
          nrd_d   = 1'b1;
          nwr_d   = 1'b1;
          if (!wr_q) rdata_d = bus.Cart_d_in;
          // rsp_valid marks the final HOLD cycle
          if (HOLD_CYC == 1) rsp_d = 1'b1;
        end
      end
      HOLD: begin
        if (done) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          ncs_d   = 1'b1;
        end else if (cnt == CNT_W'(1)) begin
          rsp_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      a_q     <= 16'h0000;
      dout_q  <= 8'h00;
      oe_q    <= 1'b0;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
      ncs_q   <= 1'b1;
      rsp_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      nrd_q   <= nrd_d;
      nwr_q   <= nwr_d;
      ncs_q   <= ncs_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rsp_valid  = rsp_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.Cart_a     = a_q;
  assign bus.Cart_d_out = dout_q;
  assign bus.Cart_d_oe  = oe_q;
  assign bus.Cart_nRD   = nrd_q;
  assign bus.Cart_nWR   = nwr_q;
  assign bus.Cart_nCS   = ncs_q;

endmodule

// File: tb/tb_gb_cart_bus_master.sv
// Scoreboard bench for gb_cart_bus_master: directed reads/writes,
// strobe/nCS shape per cycle, back-to-back, mapper and reset abort.
module tb_gb_cart_bus_master;

  typedef struct {
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   last_rsp_edge;
  logic prev_rsp;
  logic [7:0] bank;
  exp_t sb[$];

  gb_cart_bus_master_if bus ();

  gb_cart_bus_master dut (
    .sys_clock(clk),
    .sys_reset(rst),
    .bus      (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // mapper: ROM bank register lives at 0x2000-0x3FFF
  always @(posedge clk) begin
    if (rst)
      bank <= 8'h01;
    else if (!bus.Cart_nWR && bus.Cart_a[15:13] == 3'b001)
      bank <= bus.Cart_d_out;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every response pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!bus.Cart_nRD && !bus.Cart_nWR)
        chk("nrd_nwr_overlap", 1, 0);
      if (!bus.Cart_nWR && !bus.Cart_d_oe)
        chk("nwr_without_oe", 1, 0);
    end
    if (bus.rsp_valid) begin
      if (prev_rsp) chk("adjacent_rsp", 1, 0);
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", {24'h0, bus.rsp_rdata}, {24'h0, e.rdata});
        chk("rsp_latency", cyc + 1 - e.acc, 7);
      end
      last_rsp_edge = cyc + 1;
    end
    prev_rsp = bus.rsp_valid;
  end

  task automatic txn(input logic w, input logic [15:0] a,
                     input logic [7:0] wd, input logic [7:0] rd,
                     input logic [7:0] x_nrd, input logic [7:0] x_nwr,
                     input logic [7:0] x_oe, input logic [7:0] x_ncs);
    logic [7:0] m_nrd, m_nwr, m_oe, m_ncs;
    int dout_ok;
    exp_t e;
    m_nrd = 0; m_nwr = 0; m_oe = 0; m_ncs = 0; dout_ok = 0;
    @(negedge clk);
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    chk("req_ready", {31'h0, bus.req_ready}, 1);
    @(posedge clk);
    #1;
    e.rdata = rd;
    e.acc   = cyc;
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus.req_valid = 1'b0;
      m_nrd[k] = !bus.Cart_nRD;
      m_nwr[k] = !bus.Cart_nWR;
      m_oe[k]  = bus.Cart_d_oe;
      m_ncs[k] = !bus.Cart_nCS;
      if (k < 7 && bus.Cart_a == a &&
          (!w || bus.Cart_d_out == wd))
        dout_ok++;
    end
    chk("nrd_shape", {24'h0, m_nrd}, {24'h0, x_nrd});
    chk("nwr_shape", {24'h0, m_nwr}, {24'h0, x_nwr});
    chk("oe_shape", {24'h0, m_oe}, {24'h0, x_oe});
    chk("ncs_shape", {24'h0, m_ncs}, {24'h0, x_ncs});
    chk("addr_data_stable", dout_ok, 7);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n_acc;
    int gap;
    exp_t e;
    n_vec = 0; n_bad = 0; cyc = 0;
    prev_rsp = 1'b0; last_rsp_edge = -100;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 8'h0;
    bus.Cart_d_in = 8'hCE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state and idle
    chk("rst_cart_a", {16'h0, bus.Cart_a}, 0);
    chk("rst_d_out", {24'h0, bus.Cart_d_out}, 0);
    chk("rst_rdata", {24'h0, bus.rsp_rdata}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_ctrl",
          {25'h0, bus.Cart_nRD, bus.Cart_nWR, bus.Cart_nCS,
           bus.Cart_d_oe, bus.req_ready, bus.rsp_valid, bus.busy},
          32'b1110100);
    end

    // read ROM 0x0150
    txn(1'b0, 16'h0150, 8'h00, 8'hCE,
        8'h3F, 8'h00, 8'h00, 8'h00);
    // write bank select 0x2000 <- 5
    txn(1'b1, 16'h2000, 8'h05, 8'h00,
        8'h00, 8'h3C, 8'h7F, 8'h00);
    chk("mapper_bank", {24'h0, bank}, 5);
    // read cart RAM: nCS low SETUP..HOLD
    bus.Cart_d_in = 8'h5A;
    txn(1'b0, 16'hA123, 8'h00, 8'h5A,
        8'h3F, 8'h00, 8'h00, 8'h7F);
    // read 0x8000: outside cart RAM
    bus.Cart_d_in = 8'h81;
    txn(1'b0, 16'h8000, 8'h00, 8'h81,
        8'h3F, 8'h00, 8'h00, 8'h00);
    chk("ncs_after", {31'h0, bus.Cart_nCS}, 1);
    chk("addr_kept", {16'h0, bus.Cart_a}, 32'h8000);

    // back-to-back with req_valid held
    bus.Cart_d_in = 8'hCE;
    @(negedge clk);
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0150;
    bus.req_valid = 1'b1;
    n_acc = 0;
    gap = -1;
    for (int t = 0; t < 40 && n_acc < 2; t++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        n_acc++;
        e.rdata = 8'hCE;
        e.acc   = cyc;
        sb.push_back(e);
        if (n_acc == 2) gap = cyc - last_rsp_edge;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_gap", gap, 1);
    for (int t = 0; t < 30 && sb.size() != 0; t++)
      @(negedge clk);
    chk("b2b_drained", sb.size(), 0);

    // reset during STROBE of a write aborts it
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h4000;
    bus.req_wdata = 8'h33;
    bus.req_valid = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    chk("abort_in_strobe", {31'h0, bus.Cart_nWR}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctrl",
        {27'h0, bus.Cart_nWR, bus.Cart_nRD, bus.Cart_d_oe,
         bus.busy, bus.rsp_valid},
        32'b11000);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", sb.size(), 0);
    chk("abort_bank", {24'h0, bank}, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
